// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of a PWM input, derives an 8-bit
// duty level through a sequential divider, and flags inputs stuck at one level.
module pwm_capture #(
    parameter int  PWM_INTERVAL = 1200,
    parameter int  TIMEOUT      = 2 * PWM_INTERVAL,
    localparam int W            = $clog2(TIMEOUT + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pwm_in,
    output logic [W-1:0] high_count,
    output logic [W-1:0] period_count,
    output logic [7:0]   level,
    output logic         duty_valid,
    output logic         stuck_high,
    output logic         stuck_low,
    output logic         overrun
);

    localparam logic [W-1:0] TO    = W'(TIMEOUT);
    localparam logic [W-1:0] TO_M1 = W'(TIMEOUT - 1);
    localparam logic [W-1:0] ONE   = W'(1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t       state;
    logic         s1, s2, s3;
    logic         rise, fall, handoff, ge;
    logic [W-1:0] pcnt, hcnt, high_lat, div_high, div_period;
    logic [W+7:0] rem, dsh, rem_nxt, num;
    logic [7:0]   quo, quo_nxt;
    logic [3:0]   dcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise    = s2 & ~s3;
    assign fall    = ~s2 & s3;
    assign handoff = (state == LOW) && rise;
    // high*255 computed as (high<<8) - high
    assign num     = {high_lat, 8'd0} - {8'd0, high_lat};

    always_comb begin
        ge      = (rem >= dsh);
        rem_nxt = ge ? (rem - dsh) : rem;
        quo_nxt = {quo[6:0], ge};
    end

    // duty_valid and overrun are single-cycle strobes with no back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pcnt         <= '0;
            hcnt         <= '0;
            high_lat     <= '0;
            div_high     <= '0;
            div_period   <= '0;
            rem          <= '0;
            dsh          <= '0;
            quo          <= '0;
            dcnt         <= '0;
            high_count   <= '0;
            period_count <= '0;
            level        <= '0;
            duty_valid   <= 1'b0;
            stuck_high   <= 1'b0;
            stuck_low    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            overrun    <= 1'b0;

            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= HIGH;
                        pcnt  <= ONE;
                        hcnt  <= ONE;
                    end else if (pcnt == TO_M1) begin
                        pcnt         <= TO;
                        high_count   <= s2 ? TO : '0;
                        period_count <= TO;
                        level        <= s2 ? 8'd255 : 8'd0;
                        stuck_high   <= s2;
                        stuck_low    <= ~s2;
                        duty_valid   <= 1'b1;
                    end else if (pcnt != TO) begin
                        pcnt <= pcnt + ONE;
                    end
                end
                HIGH: begin
                    if (pcnt == TO) begin
                        state        <= IDLE;
                        high_count   <= TO;
                        period_count <= TO;
                        level        <= 8'd255;
                        stuck_high   <= 1'b1;
                        stuck_low    <= 1'b0;
                        duty_valid   <= 1'b1;
                    end else begin
                        pcnt <= pcnt + ONE;
                        hcnt <= hcnt + ONE;
                        if (fall) begin
                            high_lat <= hcnt;
                            state    <= LOW;
                        end
                    end
                end
                LOW: begin
                    if (rise) begin
                        state <= HIGH;
                        pcnt  <= ONE;
                        hcnt  <= ONE;
                    end else if (pcnt == TO) begin
                        state        <= IDLE;
                        high_count   <= '0;
                        period_count <= TO;
                        level        <= 8'd0;
                        stuck_high   <= 1'b0;
                        stuck_low    <= 1'b1;
                        duty_valid   <= 1'b1;
                    end else begin
                        pcnt <= pcnt + ONE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Restoring divide, one quotient bit per cycle, MSB first.
            if (dcnt != 4'd0) begin
                rem  <= rem_nxt;
                quo  <= quo_nxt;
                dsh  <= dsh >> 1;
                dcnt <= dcnt - 4'd1;
                if (dcnt == 4'd1) begin
                    high_count   <= div_high;
                    period_count <= div_period;
                    level        <= quo_nxt;
                    duty_valid   <= 1'b1;
                    stuck_high   <= 1'b0;
                    stuck_low    <= 1'b0;
                end
                if (handoff) begin
                    overrun <= 1'b1;
                end
            end else if (handoff) begin
                rem        <= num;
                dsh        <= {1'b0, pcnt, 7'd0};
                quo        <= '0;
                dcnt       <= 4'd8;
                div_high   <= high_lat;
                div_period <= pcnt;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: random and directed PWM stimulus checked every cycle against
// an event-level model of edge times, timeouts and divider occupancy.
module tb_pwm_capture;

  localparam int TIMEOUT = 2400;
  localparam int W       = $clog2(TIMEOUT + 1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pwm_in = 1'b0;
  logic [W-1:0] high_count, period_count;
  logic [7:0]   level;
  logic         duty_valid, stuck_high, stuck_low, overrun;

  pwm_capture dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwm_in       (pwm_in),
    .high_count   (high_count),
    .period_count (period_count),
    .level        (level),
    .duty_valid   (duty_valid),
    .stuck_high   (stuck_high),
    .stuck_low    (stuck_low),
    .overrun      (overrun)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int cyc = 0;
  bit [3:0] hist = '0;
  bit measuring = 0;
  bit idle_done = 0;
  int t_rise = 0, high_len = -1, idle_base = 0;
  int last_start = -100, div_due = -1, div_h = 0, div_p = 1;
  int e_high = 0, e_period = 0, e_level = 0;
  bit e_dv = 0, e_sh = 0, e_sl = 0, e_ov = 0;

  task automatic publish(input int h, input int p, input int lv, input bit sh, input bit sl);
    e_high = h; e_period = p; e_level = lv; e_sh = sh; e_sl = sl; e_dv = 1;
  endtask

  task automatic model_reset();
    cyc = 0; hist = '0; measuring = 0; idle_done = 0; t_rise = 0; high_len = -1;
    idle_base = 0; last_start = -100; div_due = -1;
    e_high = 0; e_period = 0; e_level = 0; e_dv = 0; e_sh = 0; e_sl = 0; e_ov = 0;
  endtask

  task automatic model_step();
    int c, age;
    bit r, f, lvl;
    cyc++;
    hist = {hist[2:0], pwm_in};
    c = cyc - 1;
    lvl = hist[2];
    r = hist[2] & ~hist[3];
    f = ~hist[2] & hist[3];
    e_dv = 0;
    e_ov = 0;
    if (div_due == cyc) begin
      publish(div_h, div_p, (div_h * 255) / div_p, 0, 0);
      div_due = -1;
    end
    if (!measuring) begin
      if (r) begin
        measuring = 1; t_rise = c; high_len = -1;
      end else if (!idle_done && (c - idle_base) == TIMEOUT - 1) begin
        if (lvl) publish(TIMEOUT, TIMEOUT, 255, 1, 0);
        else     publish(0, TIMEOUT, 0, 0, 1);
        idle_done = 1;
      end
    end else begin
      age = c - t_rise;
      if (high_len < 0) begin
        if (age == TIMEOUT) begin
          publish(TIMEOUT, TIMEOUT, 255, 1, 0);
          measuring = 0; idle_done = 1;
        end else if (f) begin
          high_len = age;
        end
      end else if (r) begin
        if (cyc >= last_start + 9) begin
          last_start = cyc; div_due = cyc + 8; div_h = high_len; div_p = age;
        end else begin
          e_ov = 1;
        end
        t_rise = c; high_len = -1;
      end else if (age == TIMEOUT) begin
        publish(0, TIMEOUT, 0, 0, 1);
        measuring = 0; idle_done = 1;
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- scoreboard / compare ----------------
  int lit_phase = 0;
  int dv_cnt1 = 0, sh_seen = 0, ov_cnt6 = 0, dv_since = 0;

  always @(posedge clk) begin
    #1;
    chk("high_count",   high_count,   e_high);
    chk("period_count", period_count, e_period);
    chk("level",        level,        e_level);
    chk("duty_valid",   duty_valid,   e_dv);
    chk("stuck_high",   stuck_high,   e_sh);
    chk("stuck_low",    stuck_low,    e_sl);
    chk("overrun",      overrun,      e_ov);
    if (!rst_n) dv_since = 0;
    else if (duty_valid) dv_since++;
    if (overrun && lit_phase == 6) ov_cnt6++;
    if (duty_valid) begin
      case (lit_phase)
        1: begin
          dv_cnt1++;
          chk("lit_stuck_low_cycle", cyc, 2400);
          chk("lit_stuck_low_flag", stuck_low, 1);
          chk("lit_stuck_low_level", level, 0);
          chk("lit_stuck_low_period", period_count, 2400);
          chk("lit_stuck_low_high", high_count, 0);
        end
        2: begin
          chk("lit_q_level", level, 63);
          chk("lit_q_period", period_count, 1200);
          chk("lit_q_high", high_count, 300);
          chk("lit_q_flags", {stuck_high, stuck_low}, 0);
        end
        3: chk("lit_max_level", level, 254);
        4: begin
          chk("lit_min_level", level, 0);
          chk("lit_min_high", high_count, 1);
          chk("lit_min_stuck_low", stuck_low, 0);
        end
        5: begin
          sh_seen++;
          chk("lit_sh_flag", stuck_high, 1);
          chk("lit_sh_level", level, 255);
          chk("lit_sh_high", high_count, 2400);
          chk("lit_sh_period", period_count, 2400);
        end
        6: begin
          chk("lit_short_level", level, 127);
          chk("lit_short_period", period_count, 6);
          chk("lit_short_high", high_count, 3);
        end
        default: ;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic pwm_run(input int period, input int high, input int n, input int ph);
    int warm;
    warm = 12 / period + 1;
    for (int i = 0; i < n; i++) begin
      lit_phase = (i < warm) ? 0 : ph;
      pwm_in = 1'b1;
      tick(high);
      pwm_in = 1'b0;
      tick(period - high);
    end
  endtask

  initial begin
    int p, h;
    tick(3);
    rst_n = 1'b1;

    lit_phase = 1;
    tick(2500);
    chk("stuck_low_strobes", dv_cnt1, 1);

    pwm_run(1200, 300, 3, 2);
    pwm_run(1200, 1199, 2, 3);
    pwm_run(1200, 1, 2, 4);

    lit_phase = 0;
    pwm_in = 1'b1;
    tick(20);
    lit_phase = 5;
    tick(2400);
    chk("stuck_high_strobes", sh_seen, 1);

    pwm_run(1200, 300, 3, 2);
    pwm_run(6, 3, 20, 6);
    chk("short_period_overrun_seen", ov_cnt6 > 0, 1);

    lit_phase = 0;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 4) == 0) p = $urandom_range(3, 8);
      else                           p = $urandom_range(9, 80);
      h = $urandom_range(1, p - 1);
      pwm_run(p, h, 1, 0);
    end

    // Reset in the middle of a divide.
    pwm_run(40, 10, 2, 0);
    pwm_in = 1'b1;
    tick(7);
    rst_n = 1'b0;
    #1;
    chk("rst_high_count", high_count, 0);
    chk("rst_period_count", period_count, 0);
    chk("rst_level", level, 0);
    chk("rst_duty_valid", duty_valid, 0);
    chk("rst_stuck_high", stuck_high, 0);
    chk("rst_stuck_low", stuck_low, 0);
    chk("rst_overrun", overrun, 0);
    tick(3);
    rst_n = 1'b1;
    tick(9);
    pwm_in = 1'b0;
    tick(30);
    chk("no_result_before_second_rise", dv_since, 0);
    pwm_run(40, 10, 3, 0);
    tick(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures a pulse-width-modulated input and recovers its duty cycle. It is the receive-side counterpart of the team's `pwm` generator: it reports the high time and period in clk cycles, plus an 8-bit level (0-255) derived from them. It also flags inputs stuck at a constant level. Typical use is loop-back checking of the RGB PWM outputs, or decoding an external PWM control signal into a colour or brightness value.

## Interface
- `PWM_INTERVAL`, default 1200: nominal period in clk cycles (100 µs at 12 MHz); used only to derive `TIMEOUT`.
- `TIMEOUT`, default 2*PWM_INTERVAL: cycles without a qualifying edge before the input is declared stuck. Must be ≥ 16.
- Derived constant W = $clog2(TIMEOUT+1).
- `clk`  in  1  system clock, 12 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pwm_in`  in  1  asynchronous PWM input.
- `high_count`  out  W  last measured high time, in cycles.
- `period_count`  out  W  last measured period (rising edge to rising edge), in cycles.
- `level`  out  8  floor(high_count*255/period_count).
- `duty_valid`  out  1  one-cycle strobe when the three outputs above update.
- `stuck_high`, `stuck_low`  out  1  level flags; held until the next normal measurement.
- `overrun`  out  1  one-cycle strobe when a measurement is discarded.

## Operation
**Input conditioning**
- `pwm_in` passes through a 2-flop synchronizer (s1, s2), then a third flop s3.
- rise = s2 & ~s3; fall = ~s2 & s3.

**Measurement FSM** (states IDLE, HIGH, LOW; reset state IDLE)
- IDLE:
  - On rise: high and period counters load 1, go to HIGH. Nothing is published, because there is no period reference yet.
  - Otherwise the timeout counter increments, saturating at TIMEOUT.
  - When it reaches TIMEOUT, publish a stuck result once, chosen by s2. The FSM stays in IDLE and does not re-publish.
- HIGH:
  - Both counters increment each cycle.
  - On fall: latch high = high counter, go to LOW.
  - If the period counter reaches TIMEOUT: publish stuck-high, go to IDLE.
- LOW:
  - The period counter increments each cycle.
  - On rise: hand (latched high, period counter) to the divider, reload both counters to 1, stay measuring in HIGH.
  - If the period counter reaches TIMEOUT: publish stuck-low, go to IDLE.
- Counter rule: edges at clk cycles 0 and P yield period_count = P. A fall at cycle H yields high_count = H.

**Divider**
- Sequential restoring divider. Numerator N = high*255, (W+8) bits; divisor D = period.
- Computes 8 quotient bits MSB-first, one per cycle (8 cycles). Since high < period, the quotient is ≤ 254.
- On completion, in a single cycle: `high_count`, `period_count` and `level` update, `duty_valid` pulses, and both stuck flags clear.
- If a new hand-off arrives while the divider is busy, that measurement is discarded, `overrun` pulses for 1 cycle, and the divider continues undisturbed.

**Stuck publication** (bypasses the divider; TIMEOUT ≥ 16 guarantees the divider is idle)
- stuck-high: high_count = period_count = TIMEOUT, level = 255, `stuck_high` = 1, `stuck_low` = 0.
- stuck-low: high_count = 0, period_count = TIMEOUT, level = 0, `stuck_low` = 1, `stuck_high` = 0.
- In both cases `duty_valid` pulses 1 cycle.

## Timing
- Reset (asynchronous, immediate):
  - All outputs are 0.
  - FSM goes to IDLE; synchronizer, counters and divider are cleared.
  - A divide in flight is abandoned and its result never appears.
- Rise latency: the rise strobe is high in the cycle following edge k+1, where k is the first clk edge that samples `pwm_in` high.
- Normal result latency: `duty_valid` is high in the cycle after edge k+10 (hand-off at edge k+2, 8 divide cycles).
- Stuck result latency: `duty_valid` is high in the cycle immediately after the timeout is detected.
- Minimum periods:
  - Accepted without overrun: period ≥ 9 cycles.
  - Shorter periods drop every other measurement or more.
- A simultaneous rise and timeout in LOW: the rise wins.

## Test plan
- Reset, hold `pwm_in` = 0: after TIMEOUT (2400) cycles, one `duty_valid` with `stuck_low` = 1, level = 0, period_count = 2400, high_count = 0. No further strobes while the input stays low.
- PWM with period 1200, high 300, aligned to clk: no strobe after the first rise. After the second rise, `duty_valid` with period_count = 1200, high_count = 300, level = 63. Repeats every 1200 cycles; `stuck_low` clears.
- Period 1200, high 1199: level = 254. Then period 1200, high 1: level = 0, `stuck_low` = 0.
- After valid PWM, hold `pwm_in` = 1: 2400 cycles after the last rise, `stuck_high` = 1, level = 255, high_count = period_count = 2400. Restarting the PWM clears the flag at the first normal result.
- Period 6, high 3: results alternate. Accepted results give level = 127, period_count = 6, high_count = 3; the dropped measurements each pulse `overrun`.
- Assert `rst_n` = 0 four cycles into a divide: all outputs 0 immediately. After release, no `duty_valid` appears until two new rising edges have been seen.
